// File: rtl/router_2_out_arbiter.sv
// -----------------------------------------------------------------------------
// router_2_out_arbiter
//
// Wormhole arbiter for one output port of router 2 in the 2x2 mesh. It sits
// just upstream of the output crossbar mux and drives that mux's select.
// Requests come from the North, East and Local input buffers. One request is
// granted using round-robin priority, and the grant is held from the header
// flit through the tail flit.
//
// Handshake: the arbiter moves a flit only in a cycle where the owning input
// has req=1 and out_ready=1. In that cycle, and only in that cycle, it raises
// that input's gnt (the buffer pop strobe) and drives sel_out with that input's
// code. In every other cycle all gnts are 0 and sel_out is IDLE_CODE.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   N_req      North head flit is present and routes to this output
//   E_req      East  head flit is present and routes to this output
//   L_req      Local head flit is present and routes to this output
//   N_tail     North head flit is a tail (meaningful only while N_req=1)
//   E_tail     East  head flit is a tail (meaningful only while E_req=1)
//   L_tail     Local head flit is a tail (meaningful only while L_req=1)
//   out_ready  downstream can accept a flit this cycle
//   sel_out    crossbar select, combinational
//   N_gnt      pop strobe to North buffer
//   E_gnt      pop strobe to East buffer
//   L_gnt      pop strobe to Local buffer
//   busy       registered, 1 while a packet owns the output
//   pkt_cnt    registered count of completed packets, wraps 255->0
// -----------------------------------------------------------------------------
module router_2_out_arbiter #(
  parameter int               SEL_W     = 3,
  parameter logic [SEL_W-1:0] N_CODE    = 'd0,
  parameter logic [SEL_W-1:0] E_CODE    = 'd1,
  parameter logic [SEL_W-1:0] L_CODE    = 'd4,
  parameter logic [SEL_W-1:0] IDLE_CODE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             N_req,
  input  logic             E_req,
  input  logic             L_req,
  input  logic             N_tail,
  input  logic             E_tail,
  input  logic             L_tail,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel_out,
  output logic             N_gnt,
  output logic             E_gnt,
  output logic             L_gnt,
  output logic             busy,
  output logic [7:0]       pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_N = 2'd1,
    OWN_E = 2'd2,
    OWN_L = 2'd3
  } state_t;

  // Round-robin pointer encoding: the input with the highest priority at the
  // next arbitration.
  localparam logic [1:0] RR_N = 2'd0;
  localparam logic [1:0] RR_E = 2'd1;
  localparam logic [1:0] RR_L = 2'd2;

  state_t           state;
  logic [1:0]       rr;

  state_t           pick;      // arbitration winner, IDLE if nobody requests
  logic             own_req;   // request of the current owner
  logic             own_tail;  // tail flag of the current owner
  logic [SEL_W-1:0] own_code;  // crossbar code of the current owner
  logic [1:0]       rr_succ;   // pointer value once the owner's packet ends
  logic             xfer;      // a flit moves this cycle

  // Take the first requester at or after rr, in the order N -> E -> L -> N.
  // rr never holds 2'd3. If it ever did, it would be treated like N.
  always_comb begin
    pick = IDLE;
    case (rr)
      RR_E: begin
        if (E_req)      pick = OWN_E;
        else if (L_req) pick = OWN_L;
        else if (N_req) pick = OWN_N;
      end
      RR_L: begin
        if (L_req)      pick = OWN_L;
        else if (N_req) pick = OWN_N;
        else if (E_req) pick = OWN_E;
      end
      default: begin
        if (N_req)      pick = OWN_N;
        else if (E_req) pick = OWN_E;
        else if (L_req) pick = OWN_L;
      end
    endcase
  end

  // Select the owner's request and tail signals, its crossbar code, and the
  // pointer value that follows it.
  always_comb begin
    own_req  = 1'b0;
    own_tail = 1'b0;
    own_code = IDLE_CODE;
    rr_succ  = rr;
    case (state)
      OWN_N: begin
        own_req  = N_req;
        own_tail = N_tail;
        own_code = N_CODE;
        rr_succ  = RR_E;
      end
      OWN_E: begin
        own_req  = E_req;
        own_tail = E_tail;
        own_code = E_CODE;
        rr_succ  = RR_L;
      end
      OWN_L: begin
        own_req  = L_req;
        own_tail = L_tail;
        own_code = L_CODE;
        rr_succ  = RR_N;
      end
      default: begin
        own_req  = 1'b0;
        own_tail = 1'b0;
        own_code = IDLE_CODE;
        rr_succ  = rr;
      end
    endcase
  end

  // While rst is high the outputs are forced quiet, even before the async
  // state clear has propagated.
  always_comb begin
    xfer    = own_req & out_ready & ~rst;
    sel_out = xfer ? own_code : IDLE_CODE;
    N_gnt   = xfer & (state == OWN_N);
    E_gnt   = xfer & (state == OWN_E);
    L_gnt   = xfer & (state == OWN_L);
  end

  // Ownership FSM. The arbitration cycle itself never moves a flit, so a tail
  // transfer is always followed by one IDLE cycle before the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr      <= RR_N;
      busy    <= 1'b0;
      pkt_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick != IDLE) begin
            state <= pick;
            busy  <= 1'b1;
          end
        end
        default: begin
          // The tail flag counts only on a cycle where the flit actually moves.
          if (xfer && own_tail) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rr      <= rr_succ;
            pkt_cnt <= pkt_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
